mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the CPU instruction-fetch port and its data load/store port.
- Sits between the CPU core and the unified memory macro.
- Grants one request per cycle, tracks the single outstanding read, and returns read data to the requester that owns it.
- Data accesses have priority; a starvation guard bounds fetch latency.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
RD_LAT, 2, memory read latency in cycles (grant edge to mem_rdata valid), legal range 1..7
MAX_STARVE, 3, consecutive cycles fetch may lose arbitration before it is forced to win

Ports:
clk  in  1  core clock
nreset  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; when low all state holds and no grants issue
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle (store is complete at this edge)
d_rvalid  out  1  load data valid
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_a  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe
busy  out  1  read in flight (state RD_WAIT)

Behaviour:
- Reset (nreset low, asynchronous): state IDLE, owner=none, latency counter 0, starve counter 0. All outputs 0: gnt, rvalid, mem_en, mem_we, busy. Data/address outputs 0.
- Grants and mem_* are combinational from requests and state. rvalid/rdata are registered on the owner path, or pass mem_rdata through when the counter expires.
- States:
  - IDLE: may grant.
  - RD_WAIT: read outstanding, counter counts RD_LAT-1 down to 0.
- Arbitration in IDLE, or in RD_WAIT in the cycle the counter reaches 0 (response cycle; back-to-back allowed):
  - Winner is data if d_req and starve < MAX_STARVE, else fetch if if_req, else data if d_req.
  - Exactly one gnt is high per cycle, never both.
- On grant: mem_en=1, mem_a = winner addr.
  - Store: mem_we=1, mem_wdata=d_wdata, d_gnt=1, no response, FSM remains in or returns to IDLE.
  - Read (fetch or load): mem_we=0, record owner, load counter with RD_LAT-1, go to RD_WAIT. With RD_LAT=1 the response is in the next cycle and the FSM re-arbitrates then.
- Response: in the cycle the counter is 0 in RD_WAIT, the owner's rvalid=1 and rdata=mem_rdata for exactly one cycle. The other requester's rvalid stays 0.
- Starve counter:
  - Increments (saturating at MAX_STARVE) each arbitration cycle where if_req=1 and fetch loses.
  - Clears when fetch is granted or if_req=0.
  - When it equals MAX_STARVE, fetch wins over d_req.
- Requesters hold req/addr/we/wdata stable until gnt. Dropping req before gnt is permitted and cancels it.
- clk_en low: no gnt, mem_en=0, counter and state frozen. An in-flight response is delivered only when the counter reaches 0 with clk_en high; the memory macro shares clk_en.
- nreset asserted mid-read: the outstanding read is discarded and no rvalid is produced after reset release.
- Address/data widths pass through unmodified; no alignment checks (CPU supplies word addresses with [1:0]=0).

Test Plan:
- Reset with both reqs high and nreset=0 → all gnt/rvalid/mem_en=0. After release, first cycle d_gnt=1 (data priority), mem_a=d_addr.
- Fetch only, RD_LAT=2: if_req, if_addr=0x10 → if_gnt at cycle 0, busy cycles 1..2, if_rvalid=1 with if_rdata=mem[0x10] at cycle 2, next grant same cycle.
- Store then load to 0x40: d_we=1, wdata=0xDEADBEEF, then load 0x40 → mem_we pulse, load returns 0xDEADBEEF after RD_LAT, d_rvalid only.
- Continuous d_req (loads, RD_LAT=1) plus continuous if_req, MAX_STARVE=3 → fetch granted on every 4th arbitration cycle, starve counter clears after each fetch grant.
- clk_en low for 3 cycles during RD_WAIT → no rvalid, state held. Response arrives RD_LAT enabled cycles after the grant.
- nreset pulsed while a fetch is in RD_WAIT → busy=0 immediately, no stray if_rvalid afterwards, next fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported synchronous memory between the CPU
//               instruction-fetch port and the data load/store port. Grants at
//               most one request per cycle, tracks the single outstanding read
//               and steers the returning read data to its owner. Data accesses
//               win arbitration unless fetch has lost MAX_STARVE times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clk_en,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data load/store port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory macro
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy
);

    // Latency counter holds RD_LAT-1 (at most 6), so three bits suffice.
    localparam int c_cnt_w = 3;
    localparam int c_stv_w = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_load   = c_cnt_w'(RD_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero   = '0;
    localparam logic [c_stv_w-1:0] c_starve_max = c_stv_w'(MAX_STARVE);
    localparam logic [c_stv_w-1:0] c_starve_one = c_stv_w'(1);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_rd_wait = 1'b1;

    localparam logic [1:0] c_own_none = 2'd0;
    localparam logic [1:0] c_own_if   = 2'd1;
    localparam logic [1:0] c_own_d    = 2'd2;

    logic [0:0]         state_q,  state_d;
    logic [1:0]         owner_q,  owner_d;
    logic [c_cnt_w-1:0] cnt_q,    cnt_d;
    logic [c_stv_w-1:0] starve_q, starve_d;

    logic w_rsp_cycle;
    logic w_arb;
    logic w_d_first;
    logic w_win_if;
    logic w_win_d;
    logic w_rd_grant;

    // The response cycle of an outstanding read doubles as an arbitration
    // cycle so reads can issue back to back. Nothing is granted while clk_en
    // is low, and the reset term keeps grants quiet while reset is asserted.
    assign w_rsp_cycle = (state_q == c_st_rd_wait) && (cnt_q == c_cnt_zero) && clk_en;
    assign w_arb       = nreset && clk_en &&
                         ((state_q == c_st_idle) || (cnt_q == c_cnt_zero));

    // Data has priority until fetch has lost MAX_STARVE arbitrations in a row.
    assign w_d_first   = d_req && (starve_q < c_starve_max);
    assign w_win_if    = w_arb && if_req && !w_d_first;
    assign w_win_d     = w_arb && d_req && !w_win_if;
    assign w_rd_grant  = w_win_if || (w_win_d && !d_we);

    // State register: FSM state, read owner, latency counter, starve counter.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= c_st_idle;
            owner_q  <= c_own_none;
            cnt_q    <= c_cnt_zero;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic: everything holds while clk_en is low.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;

        if (clk_en) begin
            // Count down the outstanding read; its response cycle retires it.
            if (state_q == c_st_rd_wait) begin
                if (cnt_q != c_cnt_zero) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    state_d = c_st_idle;
                    owner_d = c_own_none;
                end
            end

            // A new read (possibly in the response cycle) takes ownership.
            // Stores complete at the grant edge and leave the FSM in IDLE.
            if (w_rd_grant) begin
                state_d = c_st_rd_wait;
                owner_d = w_win_if ? c_own_if : c_own_d;
                cnt_d   = c_cnt_load;
            end
        end

        // Fetch losses are only counted when an arbitration actually happens.
        if (w_arb) begin
            if (!if_req || w_win_if) begin
                starve_d = '0;
            end else if (starve_q < c_starve_max) begin
                starve_d = starve_q + c_starve_one;
            end
        end
    end

    // Output logic: grants and memory strobes follow the arbitration result;
    // read data is steered to the registered owner in the response cycle.
    always_comb begin
        if_gnt    = w_win_if;
        d_gnt     = w_win_d;
        mem_en    = w_win_if || w_win_d;
        mem_we    = w_win_d && d_we;
        mem_a     = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        busy      = (state_q == c_st_rd_wait);

        if (w_win_if) begin
            mem_a = if_addr;
        end else if (w_win_d) begin
            mem_a = d_addr;
            if (d_we) begin
                mem_wdata = d_wdata;
            end
        end

        if (w_rsp_cycle) begin
            if (owner_q == c_own_if) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else if (owner_q == c_own_d) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
